// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Takes one character per idle cycle while i_data_valid is high and always idles at least one cycle between frames.
module uart_tx_serializer #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_data_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_busy,
    output logic                 o_tx
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BaudW      = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);
    localparam logic             OddMode  = (PARITY == 1);

    if (ClksPerBit < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY > 2) begin : gen_bad_params
        $error("uart_tx_serializer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [BaudW-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 baud_end;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        baud_end = (baud_q == BaudLast);

        unique case (state_q)
            StIdle: begin
                if (i_data_valid) begin
                    state_d = StStart;
                    shift_d = i_data;
                    // Parity bit is fixed at capture so later shifting needs no bookkeeping.
                    par_d   = (^i_data) ^ OddMode;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StParity: begin
                if (baud_end) begin
                    state_d = StStop;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line and busy are registered from the next state so they change on the transition edge.
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: five instances (8N1, 8E1, 8O1, 8N2 at 10 clk/bit, defaults at 434).
// Expected line bits are queued when a frame is launched and popped as each bit time elapses.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       valid [5];
    logic [7:0] data  [5];
    logic       tx    [5];
    logic       busy  [5];

    int n_cmp = 0;
    int n_fail = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(0)) u_n1 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[0]), .i_data(data[0]),
        .o_busy(busy[0]), .o_tx(tx[0]));
    uart_tx_serializer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(2)) u_e1 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[1]), .i_data(data[1]),
        .o_busy(busy[1]), .o_tx(tx[1]));
    uart_tx_serializer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY(1)) u_o1 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[2]), .i_data(data[2]),
        .o_busy(busy[2]), .o_tx(tx[2]));
    uart_tx_serializer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(2)) u_n2 (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[3]), .i_data(data[3]),
        .o_busy(busy[3]), .o_tx(tx[3]));
    uart_tx_serializer u_def (
        .clk(clk), .n_rst(n_rst), .i_data_valid(valid[4]), .i_data(data[4]),
        .o_busy(busy[4]), .o_tx(tx[4]));

    typedef struct {
        int         unit;
        logic [7:0] d;
        logic       par;
        int         busy_cycles;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Unit configuration: 1 = even, 2 = odd parity; 3 = two stop bits.
    task automatic push_frame(input int u, input logic [7:0] d, input logic par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (u == 1 || u == 2) exp_q.push_back(par);
        exp_q.push_back(1'b1);
        if (u == 3) exp_q.push_back(1'b1);
    endtask

    // Called on the first negedge after the acceptance edge.
    task automatic check_frame(input int u, input int exp_cycles, input string tag);
        int   cpb = (u == 4) ? 434 : 10;
        int   c = 0;
        int   nbit = 0;
        logic exp_bit = 1'b1;
        logic bad_val = 1'b0;
        bit   bad = 1'b0;
        while (busy[u] === 1'b1 && c < exp_cycles + 100) begin
            if (c % cpb == 0) begin
                exp_bit = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
                bad = 1'b0;
            end
            if (tx[u] !== exp_bit && !bad) begin
                bad = 1'b1;
                bad_val = tx[u];
            end
            if (c % cpb == cpb - 1) begin
                chk($sformatf("%s bit%0d", tag, nbit), bad ? int'(bad_val) : int'(exp_bit),
                    int'(exp_bit));
                nbit++;
            end
            c++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, c, exp_cycles);
        chk({tag, " idle tx"}, int'(tx[u]), 1);
        chk({tag, " idle busy"}, int'(busy[u]), 0);
        chk({tag, " bits left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vecs[$];

    initial begin
        for (int u = 0; u < 5; u++) begin
            valid[u] = 1'b0;
            data[u]  = 8'h00;
        end
        vecs.push_back('{0, 8'h55, 1'b0, 100});
        vecs.push_back('{0, 8'hA3, 1'b0, 100});
        vecs.push_back('{1, 8'h07, 1'b1, 110});
        vecs.push_back('{2, 8'h07, 1'b0, 110});
        vecs.push_back('{1, 8'h00, 1'b0, 110});
        vecs.push_back('{2, 8'h00, 1'b1, 110});
        vecs.push_back('{1, 8'hC1, 1'b1, 110});
        vecs.push_back('{3, 8'hA3, 1'b0, 110});
        vecs.push_back('{4, 8'hFF, 1'b0, 4340});

        // Reset state
        repeat (3) @(negedge clk);
        for (int u = 0; u < 5; u++) begin
            chk($sformatf("rst tx u%0d", u), int'(tx[u]), 1);
            chk($sformatf("rst busy u%0d", u), int'(busy[u]), 0);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames
        foreach (vecs[k]) begin
            push_frame(vecs[k].unit, vecs[k].d, vecs[k].par);
            data[vecs[k].unit]  = vecs[k].d;
            valid[vecs[k].unit] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid[vecs[k].unit] = 1'b0;
            data[vecs[k].unit]  = ~vecs[k].d;
            check_frame(vecs[k].unit, vecs[k].busy_cycles, $sformatf("vec%0d", k));
            repeat (3) @(negedge clk);
        end

        // Valid held high: two frames, data and valid disturbed mid-frame
        push_frame(0, 8'h41, 1'b0);
        data[0]  = 8'h41;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fork
            check_frame(0, 100, "b2b first");
            begin
                repeat (30) @(negedge clk);
                data[0] = 8'hFF;
                repeat (30) @(negedge clk);
                data[0] = 8'h42;
            end
        join
        push_frame(0, 8'h42, 1'b0);
        @(negedge clk);
        chk("b2b second start busy", int'(busy[0]), 1);
        chk("b2b second start tx", int'(tx[0]), 0);
        valid[0] = 1'b0;
        fork
            check_frame(0, 100, "b2b second");
            begin
                repeat (20) @(negedge clk);
                data[0] = 8'h99;
                valid[0] = 1'b1;
                @(negedge clk);
                valid[0] = 1'b0;
                repeat (20) @(negedge clk);
                data[0] = 8'h00;
            end
        join
        repeat (5) @(negedge clk);
        chk("no queued frame", int'(busy[0]), 0);

        // Reset in data bit 3, then accept on first edge after release
        data[0]  = 8'hC3;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (45) @(negedge clk);
        chk("pre-reset busy", int'(busy[0]), 1);
        chk("pre-reset data bit3", int'(tx[0]), 0);
        #2 n_rst = 1'b0;
        #1;
        chk("abort tx", int'(tx[0]), 1);
        chk("abort busy", int'(busy[0]), 0);
        data[0]  = 8'h5A;
        valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        push_frame(0, 8'h5A, 1'b0);
        n_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        check_frame(0, 100, "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
